// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter in front of a 256x8 memory
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   requester A command (held until a_gnt)
//   a_gnt                    1-cycle pulse, A command issued to memory
//   a_rvalid/a_rdata         1-cycle read-data pulse / last read data for A
//   b_*                      same set for requester B
//   mem_valid/mem_wr_en      memory write qualifiers (WR cycle only)
//   mem_wr_addr/mem_wr_data  memory write address/data
//   mem_ready/mem_rd_en      memory read qualifiers (RD cycle only)
//   mem_rd_addr              memory read address
//   mem_rd_data              memory read data, valid the cycle after the read
//   busy                     high whenever the controller is not idle
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  mem_valid,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_ready,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  rr_q, rr_d;        // 0: A has priority on contention, 1: B
    logic                  sel_q, sel_d;      // winner of the command in flight, 0: A, 1: B
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  pick_b;
    logic                  pick_we;

    // Next values of the registered outputs
    logic                  a_gnt_d, b_gnt_d;
    logic                  a_rvalid_d, b_rvalid_d;
    logic [DATA_WIDTH-1:0] a_rdata_d, b_rdata_d;
    logic                  mem_valid_d, mem_wr_en_d;
    logic [ADDR_WIDTH-1:0] mem_wr_addr_d;
    logic [DATA_WIDTH-1:0] mem_wr_data_d;
    logic                  mem_ready_d, mem_rd_en_d;
    logic [ADDR_WIDTH-1:0] mem_rd_addr_d;
    logic                  busy_d;

    // State register and command latches
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic; the command fields are only captured while idle
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        // B wins if it is the only requester, or both request and B holds priority
        pick_b  = b_req && (!a_req || rr_q);
        pick_we = pick_b ? b_we : a_we;
        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    sel_d   = pick_b;
                    addr_d  = pick_b ? b_addr : a_addr;
                    wdata_d = pick_b ? b_wdata : a_wdata;
                    rr_d    = ~pick_b;
                    state_d = pick_we ? WR : RD;
                end
            end
            WR:      state_d = IDLE;
            RD:      state_d = RD_WAIT;
            RD_WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode. Decoding from the next state lets every output be a
    // flop while still lining up with the cycle the state register is in.
    always_comb begin
        a_gnt_d       = 1'b0;
        b_gnt_d       = 1'b0;
        mem_valid_d   = 1'b0;
        mem_wr_en_d   = 1'b0;
        mem_ready_d   = 1'b0;
        mem_rd_en_d   = 1'b0;
        mem_wr_addr_d = mem_wr_addr;
        mem_wr_data_d = mem_wr_data;
        mem_rd_addr_d = mem_rd_addr;
        busy_d        = (state_d != IDLE);

        if (state_d == WR) begin
            mem_valid_d   = 1'b1;
            mem_wr_en_d   = 1'b1;
            mem_wr_addr_d = addr_d;
            mem_wr_data_d = wdata_d;
        end
        if (state_d == RD) begin
            mem_ready_d   = 1'b1;
            mem_rd_en_d   = 1'b1;
            mem_rd_addr_d = addr_d;
        end
        if (state_d == WR || state_d == RD) begin
            a_gnt_d = !sel_d;
            b_gnt_d = sel_d;
        end

        // Memory data is on mem_rd_data during RD_WAIT; it reaches the
        // winner one cycle later, together with rvalid.
        a_rvalid_d = (state_q == RD_WAIT) && !sel_q;
        b_rvalid_d = (state_q == RD_WAIT) && sel_q;
        a_rdata_d  = a_rvalid_d ? mem_rd_data : a_rdata;
        b_rdata_d  = b_rvalid_d ? mem_rd_data : b_rdata;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_gnt       <= 1'b0;
            b_gnt       <= 1'b0;
            a_rvalid    <= 1'b0;
            b_rvalid    <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            mem_valid   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_ready   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            busy        <= 1'b0;
        end else begin
            a_gnt       <= a_gnt_d;
            b_gnt       <= b_gnt_d;
            a_rvalid    <= a_rvalid_d;
            b_rvalid    <= b_rvalid_d;
            a_rdata     <= a_rdata_d;
            b_rdata     <= b_rdata_d;
            mem_valid   <= mem_valid_d;
            mem_wr_en   <= mem_wr_en_d;
            mem_wr_addr <= mem_wr_addr_d;
            mem_wr_data <= mem_wr_data_d;
            mem_ready   <= mem_ready_d;
            mem_rd_en   <= mem_rd_en_d;
            mem_rd_addr <= mem_rd_addr_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester controller that shares one single-port-style 256x8 memory (separate write and read command paths, 1-cycle registered read data) between requesters A and B.
- Accepts one command at a time from either requester and drives the memory's valid/wr_en and ready/rd_en qualifiers for exactly one cycle per command.
- Returns read data to the winning requester; round-robin arbitration.
- Sits between the two datapath masters and the memory instance.

Parameters:
- ADDR_WIDTH, 8, address width of memory and requester ports
- DATA_WIDTH, 8, data width of memory and requester ports

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- a_req  in  1  requester A command request; held until a_gnt
- a_we  in  1  A: 1=write, 0=read; stable while a_req
- a_addr  in  ADDR_WIDTH  A address
- a_wdata  in  DATA_WIDTH  A write data
- a_gnt  out  1  1-cycle pulse: A command issued to memory
- a_rvalid  out  1  1-cycle pulse: a_rdata valid
- a_rdata  out  DATA_WIDTH  A read data; holds last value
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for requester B
- mem_valid  out  1  memory write qualifier
- mem_wr_en  out  1  memory write enable
- mem_wr_addr  out  ADDR_WIDTH  memory write address
- mem_wr_data  out  DATA_WIDTH  memory write data
- mem_ready  out  1  memory read qualifier
- mem_rd_en  out  1  memory read enable
- mem_rd_addr  out  ADDR_WIDTH  memory read address
- mem_rd_data  in  DATA_WIDTH  memory read data; valid the cycle after mem_rd_en/mem_ready
- busy  out  1  high whenever state != IDLE

Behaviour:
- All outputs registered.
- Reset: state=IDLE, rr_ptr=A. All gnt, rvalid, mem_* controls, busy = 0. rdata and mem addr/data buses = 0.
- FSM states: IDLE, WR, RD, RD_WAIT.
- IDLE: sample a_req/b_req.
  - One request: select it.
  - Both requesting: select the side rr_ptr points to.
  - On select: latch we/addr/wdata, set rr_ptr to the other side, go to WR (we=1) or RD (we=0).
  - No request: stay in IDLE.
- WR (1 cycle):
  - mem_valid=1, mem_wr_en=1, mem_wr_addr/mem_wr_data = latched values.
  - Winner gnt=1.
  - Next state IDLE.
- RD (1 cycle):
  - mem_ready=1, mem_rd_en=1, mem_rd_addr = latched address.
  - Winner gnt=1.
  - Next state RD_WAIT.
- RD_WAIT (1 cycle):
  - Capture mem_rd_data into the winner's rdata.
  - Winner rvalid=1 in the following cycle (the IDLE cycle).
  - Next state IDLE.
- Latency, with req sampled in IDLE at cycle 0:
  - gnt and mem command at cycle 1.
  - Write complete at end of cycle 1.
  - Read: rvalid/rdata at cycle 3.
- Throughput:
  - Write: one per 2 cycles.
  - Read: one per 3 cycles.
  - A new request may be accepted in the same IDLE cycle that shows rvalid.
- Requester rule:
  - Requester drops req in the cycle after gnt; req sampled high in IDLE after that is a new command.
  - we/addr/wdata are captured only in IDLE, so later changes do not affect an accepted command.
- Non-winner: its gnt and rvalid stay 0; its rdata is unchanged.
- Strict alternation under continuous contention (A,B,A,B...). No starvation: a waiting side is served within one command.
- Reset mid-operation: takes priority in any state.
  - Next cycle: IDLE, all controls 0, rr_ptr=A.
  - Any pending rvalid is dropped; an in-flight read returns nothing.
  - A write is only issued if WR was entered before reset.
- Address wrap: no arithmetic; 0xFF and 0x00 are ordinary addresses.
- Memory controls are never asserted outside WR/RD. mem_valid and mem_ready are never high in the same cycle.

Test Plan:
- Reset, then idle 5 cycles -> all gnt/rvalid/mem_valid/mem_ready/busy = 0, rdata = 0.
- A writes 0x5A to 0x10, then A reads 0x10 -> a_gnt at cycle 1 with mem_wr_addr=0x10, mem_wr_data=0x5A; read shows a_rvalid=1, a_rdata=0x5A three cycles after the read request is sampled.
- A and B both request in the same cycle from reset (A write 0x11@0x01, B write 0x22@0x02) -> A granted first, B granted in the next WR cycle; memory ends with [0x01]=0x11, [0x02]=0x22.
- A and B each issue 4 back-to-back reads under continuous contention -> grant order A,B,A,B,A,B,A,B; each rvalid goes only to the issuer, with the data at its address; b_rdata is unchanged during A's reads.
- B writes 0xFF@0xFF, then reads 0xFF and 0x00 (0x00 preloaded with 0x33) -> b_rdata sequence 0xFF then 0x33.
- rst asserted during RD_WAIT of an A read -> no a_rvalid, next cycle state IDLE with busy=0; the next contended request is granted to A.
